man_frame_tx: RTL

- Manchester frame transmitter; the upstream stage that drives the serial line read by the sync capturer / Manchester decoder pair.
- Takes a 16-bit word on a start pulse and serialises one frame on `out`: sync low, sync high, 16 Manchester data bits (MSB first), one Manchester parity bit, then a trailing idle gap.
- The line idles high, matching the receiver's idle-high assumption.

---
 rtl/man_pkg.sv | 29 ++
 rtl/man_bit_encoder.sv | 13 +
 rtl/man_frame_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/man_pkg.sv
// rtl/man_pkg.sv - shared Manchester frame encoding, constants and helpers
package man_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_L,
        ST_SYNC_H,
        ST_DATA,
        ST_PARITY,
        ST_GAP
    } man_state_t;

    localparam int   DATA_W          = 16;
    localparam int   HALF_BIT_DEF    = 8;
    localparam int   SYNC_LOW_DEF    = 16;
    localparam int   SYNC_HIGH_DEF   = 16;
    localparam int   GAP_DEF         = 16;
    localparam logic PARITY_MODE_DEF = 1'b1;

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/man_bit_encoder.sv
// rtl/man_bit_encoder.sv - maps a bit value and half index to a Manchester line level
module man_bit_encoder #(
    parameter logic ONE_LOW_FIRST = 1'b1
) (
    input  logic bit_i,
    input  logic half_i,
    output logic level_o
);

    // With ONE_LOW_FIRST a 1 is low-then-high, so the level equals half for a 1 and ~half for a 0.
    assign level_o = ONE_LOW_FIRST ? ~(bit_i ^ half_i) : (bit_i ^ half_i);

endmodule

// File: rtl/man_frame_tx.sv
// rtl/man_frame_tx.sv - Manchester frame transmitter: sync low/high, 16 data bits, parity, idle gap
module man_frame_tx
    import man_pkg::*;
#(
    parameter int   HALF_BIT      = HALF_BIT_DEF,
    parameter int   SYNC_LOW      = SYNC_LOW_DEF,
    parameter int   SYNC_HIGH     = SYNC_HIGH_DEF,
    parameter int   GAP           = GAP_DEF,
    parameter logic PARITY_MODE   = PARITY_MODE_DEF,
    parameter logic ONE_LOW_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_width(HALF_BIT, SYNC_LOW, SYNC_HIGH, GAP);
    localparam logic [CW-1:0] HB_LAST  = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] SL_LAST  = CW'(SYNC_LOW - 1);
    localparam logic [CW-1:0] SH_LAST  = CW'(SYNC_HIGH - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    man_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic              half_q, half_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              enc_bit, enc_level;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        half_d  = half_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SYNC_L;
                    cnt_d   = '0;
                    shift_d = din;
                    par_d   = PARITY_MODE;
                end
            end
            ST_SYNC_L: begin
                if (cnt_q == SL_LAST) begin
                    state_d = ST_SYNC_H;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SYNC_H: begin
                if (cnt_q == SH_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    half_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        // Bit fully sent: fold it into parity and bring up the next MSB.
                        half_d  = 1'b0;
                        par_d   = par_q ^ shift_q[DATA_W-1];
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        if (bit_q == 4'd15) begin
                            state_d = ST_PARITY;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d  = 1'b0;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from next-state so the registered line lines up with the state it belongs to.
    assign enc_bit = (state_d == ST_PARITY) ? par_d : shift_d[DATA_W-1];

    man_bit_encoder #(
        .ONE_LOW_FIRST(ONE_LOW_FIRST)
    ) u_enc (
        .bit_i  (enc_bit),
        .half_i (half_d),
        .level_o(enc_level)
    );

    always_comb begin
        out_d = 1'b1;
        case (state_d)
            ST_SYNC_L:          out_d = 1'b0;
            ST_DATA, ST_PARITY: out_d = enc_level;
            default:            out_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_GAP) && (cnt_d == GAP_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= PARITY_MODE;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
